psram_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer that owns the asynchronous PSRAM bus and shares it between two requesters (port 0: audio playback reader; port 1: sample loader/recorder).
- Replaces the free-running access FSM with request/acknowledge-driven single-word transactions.
- Each transaction uses programmable wait-state timing and per-byte enables.
- Sits between the audio/loader logic and the top-level Mem*/Ram* pins.

---
 rtl/psram_arbiter_if.sv | 33 +++
 rtl/psram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_psram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// Requester-side bus of psram_arbiter: two independent request/ack ports.
// master = requester side, slave = arbiter side.
interface psram_arbiter_if #(
   parameter int unsigned ADDR_W = 23
);
   logic              req0;
   logic              we0;
   logic [1:0]        be0;
   logic [ADDR_W-1:0] addr0;
   logic [15:0]       wdata0;
   logic [15:0]       rdata0;
   logic              ack0;

   logic              req1;
   logic              we1;
   logic [1:0]        be1;
   logic [ADDR_W-1:0] addr1;
   logic [15:0]       wdata1;
   logic [15:0]       rdata1;
   logic              ack1;

   modport master (
      output req0, we0, be0, addr0, wdata0,
      output req1, we1, be1, addr1, wdata1,
      input  rdata0, ack0, rdata1, ack1
   );

   modport slave (
      input  req0, we0, be0, addr0, wdata0,
      input  req1, we1, be1, addr1, wdata1,
      output rdata0, ack0, rdata1, ack1
   );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port PSRAM arbiter / single-word transaction sequencer.
// Each granted request runs SETUP -> ACCESS (WAIT_CYCLES) -> RECOVER, with
// ack pulsed in RECOVER. Ties are resolved round-robin by default; defining
// PSRAM_ARB_FIXED_PRIO_EN gives port 0 strict priority instead.
module psram_arbiter #(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned WAIT_CYCLES = 6
) (
   input  logic              clk,
   input  logic              rst,
   psram_arbiter_if.slave    bus,
   output logic              busy,
   output logic [ADDR_W-1:0] MemAdr,
   inout  wire  [15:0]       MemDB,
   output logic              RamAdv,
   output logic              RamClk,
   output logic              RamCS,
   output logic              MemOE,
   output logic              MemWR,
   output logic              RamLB,
   output logic              RamUB
);

   if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
      $error("psram_arbiter: WAIT_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RECOVER
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              port_q;
   logic              we_q;
   logic [1:0]        be_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [15:0]       rdata0_q, rdata1_q;
   logic              gnt_valid;
   logic              gnt_port;
   logic              last_access;
   logic              drive_en;

   assign last_access = (cnt_q == 4'(WAIT_CYCLES - 1));

`ifndef PSRAM_ARB_FIXED_PRIO_EN
   logic last_grant_q;

   // Round-robin history: remembers which port was served last
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if ((state_q == S_IDLE) && gnt_valid) begin
         last_grant_q <= gnt_port;
      end
   end
`endif

   // Grant decision, only consumed while IDLE
   always_comb begin
      gnt_valid = bus.req0 | bus.req1;
`ifdef PSRAM_ARB_FIXED_PRIO_EN
      gnt_port  = ~bus.req0;
`else
      if (bus.req0 && bus.req1) begin
         gnt_port = ~last_grant_q;
      end else begin
         gnt_port = ~bus.req0;
      end
`endif
   end

   // State and wait counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter is cleared on the way into ACCESS
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = '0;
         end
         S_ACCESS: begin
            if (last_access) begin
               state_d = S_RECOVER;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RECOVER: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Latch the granted request; address persists after the transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if ((state_q == S_IDLE) && gnt_valid) begin
         port_q  <= gnt_port;
         we_q    <= gnt_port ? bus.we1    : bus.we0;
         be_q    <= gnt_port ? bus.be1    : bus.be0;
         addr_q  <= gnt_port ? bus.addr1  : bus.addr0;
         wdata_q <= gnt_port ? bus.wdata1 : bus.wdata0;
      end
   end

   // Capture read data on the final ACCESS edge into the granted port
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if ((state_q == S_ACCESS) && last_access && !we_q) begin
         if (port_q) begin
            rdata1_q <= MemDB;
         end else begin
            rdata0_q <= MemDB;
         end
      end
   end

   // PSRAM control and ack outputs decoded from the current state
   always_comb begin
      RamAdv   = 1'b1;
      RamClk   = 1'b1;
      RamCS    = 1'b1;
      MemOE    = 1'b1;
      MemWR    = 1'b1;
      RamLB    = 1'b1;
      RamUB    = 1'b1;
      drive_en = 1'b0;
      bus.ack0 = 1'b0;
      bus.ack1 = 1'b0;
      busy     = (state_q != S_IDLE);
      case (state_q)
         S_SETUP, S_ACCESS: begin
            RamAdv   = 1'b0;
            RamClk   = 1'b0;
            RamCS    = 1'b0;
            RamLB    = ~be_q[0];
            RamUB    = ~be_q[1];
            drive_en = we_q;
            if (state_q == S_ACCESS) begin
               MemOE = we_q;
               MemWR = ~we_q;
            end
         end
         S_RECOVER: begin
            drive_en = we_q;
            bus.ack0 = ~port_q;
            bus.ack1 = port_q;
         end
         default: begin
         end
      endcase
   end

   assign MemAdr     = addr_q;
   assign MemDB      = drive_en ? wdata_q : 'z;
   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_psram_arbiter;
   localparam int W = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [22:0] MemAdr;
   wire  [15:0] MemDB;
   logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
   logic [15:0] dev_data;

   always #5 clk = ~clk;

   psram_arbiter_if #(.ADDR_W(23)) bus ();

   psram_arbiter #(.ADDR_W(23), .WAIT_CYCLES(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .busy   (busy),
      .MemAdr (MemAdr),
      .MemDB  (MemDB),
      .RamAdv (RamAdv),
      .RamClk (RamClk),
      .RamCS  (RamCS),
      .MemOE  (MemOE),
      .MemWR  (MemWR),
      .RamLB  (RamLB),
      .RamUB  (RamUB)
   );

   // PSRAM device: answers reads while selected with output enable low
   assign MemDB = (!MemOE && !RamCS) ? dev_data : 'z;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0] dev_mem [logic [22:0]];
   logic [15:0] ref_mem [logic [22:0]];

   // Reference model: a transaction record plus its position k within it
   // (0 idle, 1 setup, 2..W+1 access, W+2 recover)
   int          m_k;
   logic        m_port, m_we;
   logic [1:0]  m_be;
   logic [22:0] m_addr, m_memadr;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata [2];
`ifndef PSRAM_ARB_FIXED_PRIO_EN
   logic        m_last;
`endif

   function automatic logic [15:0] dflt(input logic [22:0] a);
      return {8'hD0 ^ a[7:0], a[7:0]};
   endfunction

   function automatic logic [15:0] dev_rd(input logic [22:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [22:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic model_ack(input logic p);
      return (m_k == W + 2) && (m_port == p);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic       g;
      logic [15:0] old;
      if (rst) begin
         m_k        = 0;
         m_memadr   = '0;
         m_rdata[0] = '0;
         m_rdata[1] = '0;
`ifndef PSRAM_ARB_FIXED_PRIO_EN
         m_last     = 1'b1;
`endif
      end else if (m_k == 0) begin
         if (bus.req0 || bus.req1) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
            g = !bus.req0;
`else
            g = (bus.req0 && bus.req1) ? !m_last : !bus.req0;
            m_last = g;
`endif
            m_port   = g;
            m_we     = g ? bus.we1    : bus.we0;
            m_be     = g ? bus.be1    : bus.be0;
            m_addr   = g ? bus.addr1  : bus.addr0;
            m_wdata  = g ? bus.wdata1 : bus.wdata0;
            m_memadr = m_addr;
            m_k      = 1;
         end
      end else if (m_k == W + 1) begin
         if (!m_we) m_rdata[m_port] = ref_rd(m_addr);
         m_k = W + 2;
      end else if (m_k == W + 2) begin
         if (m_we) begin
            old = ref_rd(m_addr);
            ref_mem[m_addr] = {m_be[1] ? m_wdata[15:8] : old[15:8],
                               m_be[0] ? m_wdata[7:0]  : old[7:0]};
         end
         m_k = 0;
      end else begin
         m_k = m_k + 1;
      end
   endtask

   task automatic check_all();
      logic       in_tx, acc;
      logic [6:0] ectrl;
      in_tx = (m_k >= 1) && (m_k <= W + 1);
      acc   = (m_k >= 2) && (m_k <= W + 1);
      ectrl = in_tx ? {3'b000, ~(acc && !m_we), ~(acc && m_we), ~m_be[0], ~m_be[1]}
                    : 7'h7F;
      chk("ctrl", 32'({RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}), 32'(ectrl));
      chk("busy", 32'(busy), 32'(m_k != 0));
      chk("ack0", 32'(bus.ack0), 32'(model_ack(1'b0)));
      chk("ack1", 32'(bus.ack1), 32'(model_ack(1'b1)));
      chk("rdata0", 32'(bus.rdata0), 32'(m_rdata[0]));
      chk("rdata1", 32'(bus.rdata1), 32'(m_rdata[1]));
      chk("memadr", 32'(MemAdr), 32'(m_memadr));
      if (m_we && (m_k >= 1)) chk("memdb_wr", 32'(MemDB), 32'(m_wdata));
   endtask

   // Advance one clock: model follows the inputs the DUT will sample,
   // then outputs are checked at the falling edge
   task automatic tick();
      logic [15:0] old;
      model_step();
      @(negedge clk);
      cyc++;
      if (!MemWR && !RamCS) begin
         old = dev_rd(MemAdr);
         dev_mem[MemAdr] = {RamUB ? old[15:8] : MemDB[15:8],
                            RamLB ? old[7:0]  : MemDB[7:0]};
      end
      dev_data = dev_rd(MemAdr);
      check_all();
   endtask

   task automatic drive_req(input logic p, input logic we, input logic [1:0] be,
                            input logic [22:0] a, input logic [15:0] wd);
      if (p) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.be1 = be; bus.addr1 = a; bus.wdata1 = wd;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.be0 = be; bus.addr0 = a; bus.wdata0 = wd;
      end
   endtask

   task automatic drop_on_ack();
      if (model_ack(1'b0)) bus.req0 = 1'b0;
      if (model_ack(1'b1)) bus.req1 = 1'b0;
   endtask

   task automatic rand_req(input logic p);
      logic [22:0] a;
      a = ($urandom_range(4, 0) == 0) ? 23'h10 : 23'($urandom_range(7, 0));
      drive_req(p, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), a,
                16'($urandom_range(16'hFFFF, 0)));
   endtask

   initial begin
      logic exp_port;
      int   nack;
      dev_mem[23'h10] = 16'hA5C3;
      ref_mem[23'h10] = 16'hA5C3;
      dev_data = '0;
      m_k = 0; m_port = 0; m_we = 0; m_be = '0; m_addr = '0; m_memadr = '0; m_wdata = '0;
      m_rdata[0] = '0; m_rdata[1] = '0;
`ifndef PSRAM_ARB_FIXED_PRIO_EN
      m_last = 1'b1;
`endif
      bus.req0 = 0; bus.we0 = 0; bus.be0 = '0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.be1 = '0; bus.addr1 = '0; bus.wdata1 = '0;
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();
      chk("rst_ctrl", 32'({RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}), 32'h7F);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_adr", 32'(MemAdr), 32'h0);
      chk("rst_rdata", 32'({bus.rdata0, bus.rdata1}), 32'h0);
      rst = 1'b0;
      tick();

      // Directed read on port 0
      drive_req(1'b0, 1'b0, 2'b11, 23'h10, 16'h0);
      for (int r = 1; r <= 9; r++) begin
         tick();
         if (r == 1) chk("rd_setup", 32'({busy, RamCS, MemOE}), 32'h5);
         if (r >= 2 && r <= 7) chk("rd_oe_low", 32'(MemOE), 32'h0);
         if (r == 8) begin
            chk("rd_ack0", 32'(bus.ack0), 32'h1);
            chk("rd_data", 32'(bus.rdata0), 32'hA5C3);
         end
         if (r == 9) chk("rd_busy_end", 32'(busy), 32'h0);
         drop_on_ack();
      end

      // Directed low-byte write on port 1
      drive_req(1'b1, 1'b1, 2'b01, 23'h3, 16'h1234);
      for (int r = 1; r <= 9; r++) begin
         tick();
         if (r <= 8) begin
            chk("wr_db", 32'(MemDB), 32'h1234);
            chk("wr_adr", 32'(MemAdr), 32'h3);
         end
         if (r >= 2 && r <= 7) chk("wr_wr_lb_ub", 32'({MemWR, RamLB, RamUB}), 32'h1);
         if (r == 8) chk("wr_ack1", 32'(bus.ack1), 32'h1);
         drop_on_ack();
      end

      // Read back: only the low byte was replaced
      drive_req(1'b0, 1'b0, 2'b11, 23'h3, 16'h0);
      for (int r = 1; r <= 9; r++) begin
         tick();
         if (r == 8) chk("rdback", 32'(bus.rdata0), 32'hD334);
         drop_on_ack();
      end

      // Reset during the third ACCESS cycle of a port 1 read
      drive_req(1'b1, 1'b0, 2'b11, 23'h5, 16'h0);
      for (int r = 1; r <= 4; r++) tick();
      rst = 1'b1;
      tick();
      chk("abort_ctrl", 32'({RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}), 32'h7F);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_ack", 32'({bus.ack0, bus.ack1}), 32'h0);
      rst = 1'b0;

      // Both ports held high: acks at 8, 17, 26, 35
      drive_req(1'b0, 1'b0, 2'b11, 23'h10, 16'h0);
      nack = 0;
      for (int r = 1; r <= 36; r++) begin
         tick();
         if (r == 8 || r == 17 || r == 26 || r == 35) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = nack[0];
`endif
            chk("tie_ack", 32'({bus.ack1, bus.ack0}), exp_port ? 32'h2 : 32'h1);
            nack++;
         end else begin
            chk("tie_noack", 32'({bus.ack1, bus.ack0}), 32'h0);
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int r = 0; r < 12; r++) tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(399, 0) == 0) begin
            rst = 1'b1;
         end
         drop_on_ack();
         if (!bus.req0 && !model_ack(1'b0) && $urandom_range(3, 0) == 0) rand_req(1'b0);
         if (!bus.req1 && !model_ack(1'b1) && $urandom_range(3, 0) == 0) rand_req(1'b1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
